wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 97 +++++++++
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

  typedef logic [4:0] regaddr_t;

  localparam int WB_W = 32;

  typedef struct packed {
    regaddr_t          wa;
    logic [WB_W-1:0]   wd;
  } wb_req_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  // Address 0 is the hardwired zero register: never written, never a hazard.
  function automatic logic is_live(input regaddr_t a);
    return (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-return FIFO: circular storage, wrap-around pointers, occupancy count and
// per-entry destination-address match against two hazard query addresses.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [4:0]       push_wa,
  input  logic [W-1:0]     push_wd,
  input  logic             pop,
  output logic [4:0]       head_wa,
  output logic [W-1:0]     head_wd,
  output logic             empty,
  output logic             full,
  input  logic [4:0]       qa1,
  input  logic [4:0]       qa2,
  output logic [DEPTH-1:0] hit1,
  output logic [DEPTH-1:0] hit2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    wa_mem_r [DEPTH];
  logic [W-1:0]  wd_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          do_push_s;
  logic          do_pop_s;
  logic [PW-1:0] offset_s [DEPTH];

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head_wa   = wa_mem_r[rd_ptr_r];
  assign head_wd   = wd_mem_r[rd_ptr_r];

  // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        wa_mem_r[i] <= 5'd0;
        wd_mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        wa_mem_r[wr_ptr_r] <= push_wa;
        wd_mem_r[wr_ptr_r] <= push_wd;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    hit1 = {DEPTH{1'b0}};
    hit2 = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offset_s[i] = PW'(i) - rd_ptr_r;
      if ({1'b0, offset_s[i]} < count_r) begin
        hit1[i] = is_live(qa1) && (wa_mem_r[i] == qa1);
        hit2[i] = is_live(qa2) && (wa_mem_r[i] == qa2);
      end else begin
        hit1[i] = 1'b0;
        hit2[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results take priority, load returns queue
// in wb_fifo. Define WB_BYPASS_EN to let a load on an idle cycle skip the FIFO.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         alu_valid,
  input  logic [4:0]   alu_wa,
  input  logic [W-1:0] alu_wd,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [4:0]   ld_wa,
  input  logic [W-1:0] ld_wd,
  input  logic [4:0]   qa1,
  input  logic [4:0]   qa2,
  output logic         q_pend1,
  output logic         q_pend2,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [W-1:0] wd3
);

  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [4:0]       head_wa_s;
  logic [W-1:0]     head_wd_s;
  logic [DEPTH-1:0] hit1_s;
  logic [DEPTH-1:0] hit2_s;

  logic             accept_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;

  logic             we3_r;
  logic [4:0]       wa3_r;
  logic [W-1:0]     wd3_r;
  logic             src_ld_r;

  logic             we3_nxt_s;
  logic [4:0]       wa3_nxt_s;
  logic [W-1:0]     wd3_nxt_s;
  logic             src_ld_nxt_s;

  assign ld_ready = !fifo_full_s;
  assign accept_s = ld_valid && ld_ready;
  assign pop_s    = !alu_valid && !fifo_empty_s;

`ifdef WB_BYPASS_EN
  assign bypass_s = accept_s && fifo_empty_s && !alu_valid;
`else
  assign bypass_s = 1'b0;
`endif
  assign push_s   = accept_s && !bypass_s;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .push_wa (ld_wa),
    .push_wd (ld_wd),
    .pop     (pop_s),
    .head_wa (head_wa_s),
    .head_wd (head_wd_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s),
    .qa1     (qa1),
    .qa2     (qa2),
    .hit1    (hit1_s),
    .hit2    (hit2_s)
  );

  // Output-register source select: ALU, then FIFO head, then bypassed load.
  always_comb begin
    we3_nxt_s    = 1'b0;
    wa3_nxt_s    = wa3_r;
    wd3_nxt_s    = wd3_r;
    src_ld_nxt_s = 1'b0;
    if (alu_valid) begin
      we3_nxt_s    = is_live(alu_wa);
      wa3_nxt_s    = alu_wa;
      wd3_nxt_s    = alu_wd;
      src_ld_nxt_s = 1'b0;
    end else if (pop_s) begin
      we3_nxt_s    = is_live(head_wa_s);
      wa3_nxt_s    = head_wa_s;
      wd3_nxt_s    = head_wd_s;
      src_ld_nxt_s = 1'b1;
    end else if (bypass_s) begin
      we3_nxt_s    = is_live(ld_wa);
      wa3_nxt_s    = ld_wa;
      wd3_nxt_s    = ld_wd;
      src_ld_nxt_s = 1'b1;
    end else begin
      we3_nxt_s    = 1'b0;
      src_ld_nxt_s = 1'b0;
    end
  end

  // Writeback output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3_r    <= 1'b0;
      wa3_r    <= 5'd0;
      wd3_r    <= {W{1'b0}};
      src_ld_r <= 1'b0;
    end else begin
      we3_r    <= we3_nxt_s;
      wa3_r    <= wa3_nxt_s;
      wd3_r    <= wd3_nxt_s;
      src_ld_r <= src_ld_nxt_s;
    end
  end

  assign we3 = we3_r;
  assign wa3 = wa3_r;
  assign wd3 = wd3_r;

  // A load sitting in the output register is still pending until its write lands.
  assign q_pend1 = (|hit1_s) || (src_ld_r && we3_r && is_live(qa1) && (wa3_r == qa1));
  assign q_pend2 = (|hit2_s) || (src_ld_r && we3_r && is_live(qa2) && (wa3_r == qa2));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter plus reset and bypass sequences.
module tb_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_wa;
  logic [31:0] ld_wd;
  logic [4:0]  qa1;
  logic [4:0]  qa2;
  logic        q_pend1;
  logic        q_pend2;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.DEPTH(4), .W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_wa     (ld_wa),
    .ld_wd     (ld_wd),
    .qa1       (qa1),
    .qa2       (qa2),
    .q_pend1   (q_pend1),
    .q_pend2   (q_pend2),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aw;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lw;
    logic [31:0] ld;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        p1;
    logic        p2;
    logic        cd;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(
    input logic av, input logic [4:0] aw, input logic [31:0] ad,
    input logic lv, input logic [4:0] lw, input logic [31:0] ld,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic rdy, input logic p1, input logic p2, input logic cd);
    vec_t v;
    v.av = av; v.aw = aw; v.ad = ad; v.lv = lv; v.lw = lw; v.ld = ld;
    v.q1 = q1; v.q2 = q2; v.we = we; v.wa = wa; v.wd = wd;
    v.rdy = rdy; v.p1 = p1; v.p2 = p2; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lw, input logic [31:0] ld,
                       input logic [4:0] q1, input logic [4:0] q2);
    alu_valid = av; alu_wa = aw; alu_wd = ad;
    ld_valid = lv; ld_wa = lw; ld_wd = ld;
    qa1 = q1; qa2 = q2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    reset_n = 1'b0;

    // ALU only, hold on idle
    tbl[0]  = mk(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,  1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd5, 5'd0,  1'b0, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
    // contention: ALU wa=3 four cycles, load wa=7 retires right after
    tbl[2]  = mk(1'b1, 5'd3, 32'hA0, 1'b1, 5'd7, 32'h70, 5'd7, 5'd3,  1'b1, 5'd3, 32'hA0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[3]  = mk(1'b1, 5'd3, 32'hA1, 1'b0, 5'd0, 32'h0,  5'd7, 5'd3,  1'b1, 5'd3, 32'hA1, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[4]  = mk(1'b1, 5'd3, 32'hA2, 1'b0, 5'd0, 32'h0,  5'd7, 5'd3,  1'b1, 5'd3, 32'hA2, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'h0,  5'd7, 5'd3,  1'b1, 5'd3, 32'hA3, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd3,  1'b1, 5'd7, 32'h70, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd3,  1'b0, 5'd7, 32'h70, 1'b1, 1'b0, 1'b0, 1'b1);
    // fill under ALU pressure, 5th load dropped, full+pop keeps ready low
    tbl[8]  = mk(1'b1, 5'd1, 32'h10, 1'b1, 5'd10, 32'hB0, 5'd10, 5'd13, 1'b1, 5'd1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'hB1, 5'd10, 5'd13, 1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 5'd1, 32'h12, 1'b1, 5'd12, 32'hB2, 5'd10, 5'd13, 1'b1, 5'd1, 32'h12, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 5'd1, 32'h13, 1'b1, 5'd13, 32'hB3, 5'd10, 5'd13, 1'b1, 5'd1, 32'h13, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[12] = mk(1'b1, 5'd1, 32'h14, 1'b1, 5'd14, 32'hB4, 5'd14, 5'd13, 1'b1, 5'd1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 5'd0, 32'h0,  1'b1, 5'd15, 32'hC0, 5'd10, 5'd15, 1'b1, 5'd10, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd10, 5'd14, 1'b1, 5'd11, 32'hB1, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd12, 5'd13, 1'b1, 5'd12, 32'hB2, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[16] = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd12, 5'd13, 1'b1, 5'd13, 32'hB3, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[17] = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd13, 5'd15, 1'b0, 5'd13, 32'hB3, 1'b1, 1'b0, 1'b0, 1'b1);
    // zero register: ALU and load to r0 consumed without a write
    tbl[18] = mk(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0,  5'd0, 5'd0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'h55, 5'd0, 5'd2,  1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[20] = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 5'd0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0);
    tbl[21] = mk(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0);

    tick();
    tick();
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_wa3", {27'd0, wa3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_pend", {30'd0, q_pend1, q_pend2}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_rdy", {31'd0, ld_ready}, 32'd1);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].av, tbl[i].aw, tbl[i].ad, tbl[i].lv, tbl[i].lw, tbl[i].ld, tbl[i].q1, tbl[i].q2);
      tick();
      chk($sformatf("v%0d_we3", i), {31'd0, we3}, {31'd0, tbl[i].we});
      if (tbl[i].cd) begin
        chk($sformatf("v%0d_wa3", i), {27'd0, wa3}, {27'd0, tbl[i].wa});
        chk($sformatf("v%0d_wd3", i), wd3, tbl[i].wd);
      end else begin
        total = total;
      end
      chk($sformatf("v%0d_rdy", i), {31'd0, ld_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d_p1", i), {31'd0, q_pend1}, {31'd0, tbl[i].p1});
      chk($sformatf("v%0d_p2", i), {31'd0, q_pend2}, {31'd0, tbl[i].p2});
    end

    // bypass: load wa=9 on an idle cycle
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h900, 5'd9, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
`ifdef WB_BYPASS_EN
    chk("byp_we3_e1", {31'd0, we3}, 32'd1);
    chk("byp_wa3_e1", {27'd0, wa3}, 32'd9);
    chk("byp_wd3_e1", wd3, 32'h900);
    chk("byp_p1_e1", {31'd0, q_pend1}, 32'd1);
    tick();
    chk("byp_we3_e2", {31'd0, we3}, 32'd0);
    chk("byp_p1_e2", {31'd0, q_pend1}, 32'd0);
`else
    chk("byp_we3_e1", {31'd0, we3}, 32'd0);
    chk("byp_p1_e1", {31'd0, q_pend1}, 32'd1);
    tick();
    chk("byp_we3_e2", {31'd0, we3}, 32'd1);
    chk("byp_wa3_e2", {27'd0, wa3}, 32'd9);
    chk("byp_wd3_e2", wd3, 32'h900);
    chk("byp_p1_e2", {31'd0, q_pend1}, 32'd1);
    tick();
    chk("byp_we3_e3", {31'd0, we3}, 32'd0);
    chk("byp_p1_e3", {31'd0, q_pend1}, 32'd0);
`endif

    // reset mid-stream with three loads buffered behind the ALU
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd4, 32'h40 + 32'(i), 1'b1, 5'd20 + 5'(i), 32'hD0 + 32'(i), 5'd21, 5'd22);
      tick();
    end
    chk("mid_pend1", {31'd0, q_pend1}, 32'd1);
    chk("mid_we3", {31'd0, we3}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we3", {31'd0, we3}, 32'd0);
    chk("arst_rdy", {31'd0, ld_ready}, 32'd1);
    chk("arst_pend", {30'd0, q_pend1, q_pend2}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd21, 5'd22);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d_we3", i), {31'd0, we3}, 32'd0);
      chk($sformatf("post_rst%0d_pend", i), {30'd0, q_pend1, q_pend2}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
